servo_move_sequencer: RTL
=========================

SERVO_MOVE_SEQUENCER -- requirements
Module: servo_move_sequencer

Interface
REQ-001 Parameter TICKS_PER_MS, default 50000, is the number of clk cycles per millisecond (50 MHz clock).
REQ-002 Parameter SETTLE_MS, default 20, is the stop-hold time in milliseconds after every move; 0 is legal.
REQ-003 Single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  move command present.
REQ-007 cmd_dir  input  3  direction code: 000 stop, 001 forward, 010 backward, 011 left, 100 right.
REQ-008 cmd_ms  input  16  move duration in milliseconds.
REQ-009 cmd_ready  output  1  command acceptance window.
REQ-010 abort  input  1  terminate the current move early.
REQ-011 direction  output  3  direction code for the servo controller.
REQ-012 useServo  output  1  one-cycle load strobe for direction.
REQ-013 busy  output  1  high whenever the sequencer is not idle.
REQ-014 done  output  1  one-cycle pulse when a command completes.

Function
REQ-015 The sequencer SHALL have states INIT, IDLE, MOVE and SETTLE; busy SHALL be 1 in every state except IDLE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted at a rising edge where cmd_valid and cmd_ready are both 1.
REQ-017 At acceptance, a cmd_dir value above 100 SHALL be captured as 000.
REQ-018 Acceptance with cmd_ms > 0 SHALL enter MOVE at that edge, with direction set to the captured code and useServo driven to 1 for exactly that next cycle.
REQ-019 direction SHALL hold the captured code for exactly cmd_ms*TICKS_PER_MS cycles, timed by a tick counter (0..TICKS_PER_MS-1) and a 16-bit millisecond down-counter.
REQ-020 At MOVE terminal count, the block SHALL enter SETTLE, set direction to 000 and pulse useServo for one cycle.
REQ-021 Acceptance with cmd_ms = 0 SHALL enter SETTLE directly, set direction to 000 and pulse useServo; the captured code never appears on direction.
REQ-022 SETTLE SHALL last SETTLE_MS*TICKS_PER_MS cycles, or 1 cycle if SETTLE_MS = 0, and then enter IDLE with done = 1 for that single cycle.
REQ-023 abort sampled high in MOVE SHALL enter SETTLE at that edge, with the same stop action as REQ-020.
REQ-024 abort in INIT, IDLE or SETTLE SHALL be ignored.
REQ-025 abort and terminal count coinciding in MOVE SHALL produce one transition and one useServo pulse.
REQ-026 cmd_valid while busy SHALL be ignored; no command is queued.
REQ-027 useServo SHALL never be high for two consecutive cycles.
REQ-028 direction SHALL change only in a cycle where useServo is 1.
REQ-029 Counters SHALL be sized from the parameters and SHALL NOT wrap within any legal command.

Reset
REQ-030 While reset is high, the block SHALL force state INIT, direction 000, useServo 0, done 0, busy 1, cmd_ready 0 and clear all counters, asynchronously.
REQ-031 On the first rising edge after reset deasserts, INIT SHALL drive useServo 1 for one cycle with direction 000, so a stale latched servo direction is cleared; the next edge SHALL enter IDLE.
REQ-032 Reset asserted during MOVE or SETTLE SHALL abandon the command with no done pulse.

Verification (TICKS_PER_MS=4, SETTLE_MS=2)
REQ-033 Release reset -> one useServo pulse with direction 000, then IDLE with cmd_ready 1 and busy 0.
REQ-034 Command dir 001, ms 3 -> useServo pulse with direction 001, 001 held for 12 cycles, stop pulse, 8 cycles of 000, done pulse, then cmd_ready 1.
REQ-035 Command dir 011, ms 0 -> direction stays 000, one stop pulse, 8 cycles of SETTLE, then done.
REQ-036 Command dir 100, ms 5 with abort at MOVE cycle 6 -> stop pulse at the next cycle, 8 cycles of SETTLE, then done; cmd_valid pulsed during MOVE is not accepted.
REQ-037 Command dir 111, ms 2 -> direction 000 for 8 cycles, with exactly 2 useServo pulses in total.
REQ-038 Reset asserted in MOVE cycle 3 -> direction 000 immediately, no done pulse, and the post-release stop pulse per REQ-031.

Source files
------------

// File: rtl/servo_move_sequencer.sv
// Servo move sequencer: turns timed direction commands into one-cycle
// direction load strobes for a servo controller, holds a stop/settle
// interval after every move and reports completion with a done pulse.
module servo_move_sequencer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int SETTLE_MS    = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_dir,
  input  logic [15:0] cmd_ms,
  output logic        cmd_ready,
  input  logic        abort,
  output logic [2:0]  direction,
  output logic        useServo,
  output logic        busy,
  output logic        done
);

  // Tick counter runs 0..TICKS_PER_MS-1 inside each millisecond of a move.
  localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);

  // Settle interval in cycles; a zero-length settle still costs one cycle.
  localparam int SETTLE_CYC = (SETTLE_MS == 0) ? 1 : SETTLE_MS * TICKS_PER_MS;
  localparam int SETTLE_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  localparam logic [2:0] DIR_STOP = 3'd0;
  localparam logic [2:0] DIR_MAX  = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_MOVE   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Codes outside stop/forward/backward/left/right are treated as stop.
  function automatic logic [2:0] legal_dir(input logic [2:0] code);
    logic [2:0] res;
    if (code > DIR_MAX) begin
      res = DIR_STOP;
    end else begin
      res = code;
    end
    return res;
  endfunction

  state_t              state_r, state_s;
  logic                init_pulsed_r, init_pulsed_s;
  logic [TICK_W-1:0]   tick_r, tick_s;
  logic [15:0]         ms_left_r, ms_left_s;
  logic [SETTLE_W-1:0] settle_r, settle_s;
  logic [2:0]          dir_r, dir_s;
  logic                use_r, use_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
  logic                ready_r, ready_s;
  logic                move_last_s;

  assign direction = dir_r;
  assign useServo  = use_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign cmd_ready = ready_r;

  // State, counters and all outputs are registered; reset parks the block in INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_INIT;
      init_pulsed_r <= 1'b0;
      tick_r        <= {TICK_W{1'b0}};
      ms_left_r     <= 16'd0;
      settle_r      <= {SETTLE_W{1'b0}};
      dir_r         <= DIR_STOP;
      use_r         <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b1;
      ready_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      init_pulsed_r <= init_pulsed_s;
      tick_r        <= tick_s;
      ms_left_r     <= ms_left_s;
      settle_r      <= settle_s;
      dir_r         <= dir_s;
      use_r         <= use_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
      ready_r       <= ready_s;
    end
  end

  // Next-state logic: strobes default low, everything else holds.
  always_comb begin
    state_s       = state_r;
    init_pulsed_s = init_pulsed_r;
    tick_s        = tick_r;
    ms_left_s     = ms_left_r;
    settle_s      = settle_r;
    dir_s         = dir_r;
    use_s         = 1'b0;
    done_s        = 1'b0;
    move_last_s   = (tick_r == TICK_LAST) && (ms_left_r == 16'd0);

    case (state_r)
      ST_INIT: begin
        // First cycle out of reset re-loads stop into the servo so a stale
        // latched direction cannot persist; the following cycle goes idle.
        if (!init_pulsed_r) begin
          init_pulsed_s = 1'b1;
          dir_s         = DIR_STOP;
          use_s         = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (cmd_valid && ready_r) begin
          use_s  = 1'b1;
          tick_s = {TICK_W{1'b0}};
          if (cmd_ms != 16'd0) begin
            state_s   = ST_MOVE;
            dir_s     = legal_dir(cmd_dir);
            ms_left_s = cmd_ms - 16'd1;
          end else begin
            // Zero-length move: only the stop action is issued.
            state_s  = ST_SETTLE;
            dir_s    = DIR_STOP;
            settle_s = SETTLE_LAST;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_MOVE: begin
        // Abort and terminal count share one exit path, so they can never
        // produce two transitions or two strobes.
        if (abort || move_last_s) begin
          state_s  = ST_SETTLE;
          dir_s    = DIR_STOP;
          use_s    = 1'b1;
          settle_s = SETTLE_LAST;
        end else if (tick_r == TICK_LAST) begin
          tick_s    = {TICK_W{1'b0}};
          ms_left_s = ms_left_r - 16'd1;
        end else begin
          tick_s = tick_r + TICK_W'(1);
        end
      end

      ST_SETTLE: begin
        if (settle_r == {SETTLE_W{1'b0}}) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          settle_s = settle_r - SETTLE_W'(1);
        end
      end

      default: begin
        state_s = ST_INIT;
        dir_s   = DIR_STOP;
      end
    endcase

    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_IDLE);
  end

endmodule
